regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the processor's general-purpose register file.
- Two read ports and two write ports.
- A hardware initialisation sweep loads every register after reset, replacing simulation-only initial values.
- Optional write-to-read bypass lets same-cycle writeback data reach decode without a pipeline stall.
- Sits between decode (read ports) and writeback (write ports) of the 32-bit MIPS datapath.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- INIT_MODE, 1: sweep value; 0 = all zeros, 1 = register index zero-extended to DATA_W.
- BYPASS, 1: 1 = read ports return same-cycle write data on address match; 0 = reads return stored contents only.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- reg_write_en  in  1  write port A enable.
- reg_write_dest  in  ADDR_W  write port A address.
- reg_write_data  in  DATA_W  write port A data.
- reg_write_en_2  in  1  write port B enable.
- reg_write_dest_2  in  ADDR_W  write port B address.
- reg_write_data_2  in  DATA_W  write port B data.
- reg_read_addr_1  in  ADDR_W  read port 1 address.
- reg_read_data_1  out  DATA_W  read port 1 data (combinational).
- reg_read_addr_2  in  ADDR_W  read port 2 address.
- reg_read_data_2  out  DATA_W  read port 2 data (combinational).
- ready  out  1  high once the init sweep is complete; file accepts writes and returns valid reads.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- FSM states: INIT, RUN.
- Reset action: any edge with reset=1 sets state=INIT, init_cnt=0, ready=0. Register contents are not cleared by reset itself.
- INIT state:
  - Each edge with reset=0 writes init_val(init_cnt) to mem[init_cnt], then init_cnt += 1.
  - On the edge writing entry DEPTH-1, state becomes RUN and ready=1.
  - ready therefore rises exactly DEPTH edges after the first edge with reset=0 (32 with defaults).
  - All external write enables are ignored; no write is queued.
  - reg_read_data_1/2 = 0.
  - A reset asserted mid-sweep restarts the sweep from index 0.
- RUN state:
  - On each edge, if reg_write_en=1, mem[reg_write_dest] <= reg_write_data.
  - On each edge, if reg_write_en_2=1, mem[reg_write_dest_2] <= reg_write_data_2.
  - Both ports enabled to the same address: port B wins.
  - With ZERO_REG=1, writes to address 0 are discarded on either port.
- Read ports:
  - Purely combinational; zero-latency from address to data.
  - Output priority, highest first:
    - (a) ready=0 -> 0.
    - (b) ZERO_REG=1 and addr=0 -> 0.
    - (c) BYPASS=1 and port B enabled with dest==addr -> reg_write_data_2.
    - (d) BYPASS=1 and port A enabled with dest==addr -> reg_write_data.
    - (e) mem[addr].
  - With BYPASS=0, a written value is visible on reads from the cycle after the write edge.
- Width rules:
  - Addresses are always in range; DEPTH is a power of two.
  - init_cnt is ADDR_W+1 bits so the terminal count does not wrap.
  - INIT_MODE=1 index is zero-extended, or truncated if DATA_W < ADDR_W.
- Reset values: ready=0; read outputs 0 while ready=0.

Test Plan:
- Init sweep:
  - Stimulus: reset high 2 cycles, then low; defaults.
  - ready=0 for 31 edges and goes to 1 on the 32nd.
  - Afterwards addr 7 reads 0x00000007, addr 31 reads 0x0000001F, addr 0 reads 0.
- Write during INIT:
  - Stimulus: reg_write_en=1, dest=5, data=0xDEADBEEF at sweep cycle 3.
  - After ready, addr 5 reads 0x00000005.
- Dual write collision:
  - Stimulus: in RUN, both ports write addr 9, A=0x11111111, B=0x22222222.
  - Next cycle, addr 9 reads 0x22222222.
  - Same stimulus to addr 0 leaves it reading 0.
- Bypass:
  - Stimulus: BYPASS=1; read_addr_1=12 while port A writes 12 with 0xCAFEF00D.
  - reg_read_data_1=0xCAFEF00D in the same cycle.
  - With BYPASS=0 it reads 0x0000000C that cycle and 0xCAFEF00D the next.
- Reset mid-sweep and after writes:
  - Stimulus: write 0xABCD to reg 3 in RUN, assert reset 1 cycle, then re-assert reset at sweep cycle 10.
  - ready=0 throughout; ready rises 32 edges after the final reset deassert.
  - Reg 3 reads 0x00000003.
- Config variant:
  - Stimulus: DATA_W=16, ADDR_W=3, INIT_MODE=0, ZERO_REG=0.
  - ready after 8 edges; all regs read 0.
  - A write of 0xBEEF to reg 0 reads back 0xBEEF.

Source files
------------

// File: rtl/regfile_multiport_if.sv
// Bundle of the register file's read and write ports between decode/writeback (master)
// and the register file (slave).
interface regfile_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic              reg_write_en_2;
    logic [ADDR_W-1:0] reg_write_dest_2;
    logic [DATA_W-1:0] reg_write_data_2;
    logic [ADDR_W-1:0] reg_read_addr_1;
    logic [DATA_W-1:0] reg_read_data_1;
    logic [ADDR_W-1:0] reg_read_addr_2;
    logic [DATA_W-1:0] reg_read_data_2;
    logic              ready;

    modport master (
        output reg_write_en, reg_write_dest, reg_write_data,
        output reg_write_en_2, reg_write_dest_2, reg_write_data_2,
        output reg_read_addr_1, reg_read_addr_2,
        input  reg_read_data_1, reg_read_data_2, ready
    );

    modport slave (
        input  reg_write_en, reg_write_dest, reg_write_data,
        input  reg_write_en_2, reg_write_dest_2, reg_write_data_2,
        input  reg_read_addr_1, reg_read_addr_2,
        output reg_read_data_1, reg_read_data_2, ready
    );
endinterface

// File: rtl/regfile_multiport.sv
// Two-read/two-write register file with a post-reset initialisation sweep and an
// optional write-to-read bypass.
module regfile_multiport #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input logic                 clk,
    input logic                 reset,
    regfile_multiport_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W:0]   init_cnt;
    logic              ready_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] init_idx;
    logic [DATA_W-1:0] init_val;

    assign init_idx = init_cnt[ADDR_W-1:0];
    assign init_val = (INIT_MODE == 1) ? DATA_W'(init_idx) : '0;
    assign bus.ready = ready_q;

    // NOTE: state registers use non-blocking assignments so every always_ff sees
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_IDX) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset branch; the sweep loads it instead, which
    // keeps it mappable to plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[init_idx] <= init_val;
            end else begin
                // Port B is written last so it wins a same-address collision.
                if (bus.reg_write_en && !(ZERO_REG == 1 && bus.reg_write_dest == '0))
                    mem[bus.reg_write_dest] <= bus.reg_write_data;
                if (bus.reg_write_en_2 && !(ZERO_REG == 1 && bus.reg_write_dest_2 == '0))
                    mem[bus.reg_write_dest_2] <= bus.reg_write_data_2;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              rdy,
        input logic              we_a,
        input logic [ADDR_W-1:0] dest_a,
        input logic [DATA_W-1:0] data_a,
        input logic              we_b,
        input logic [ADDR_W-1:0] dest_b,
        input logic [DATA_W-1:0] data_b,
        input logic [DATA_W-1:0] stored
    );
        if (!rdy)                                 return '0;
        if (ZERO_REG == 1 && addr == '0)          return '0;
        if (BYPASS == 1 && we_b && dest_b == addr) return data_b;
        if (BYPASS == 1 && we_a && dest_a == addr) return data_a;
        return stored;
    endfunction

    // NOTE: purely combinational read path; every output is assigned on every path
    // through the function, so no latch is inferred.
    always_comb begin
        bus.reg_read_data_1 = read_port(bus.reg_read_addr_1, ready_q,
            bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data,
            bus.reg_write_en_2, bus.reg_write_dest_2, bus.reg_write_data_2,
            mem[bus.reg_read_addr_1]);
        bus.reg_read_data_2 = read_port(bus.reg_read_addr_2, ready_q,
            bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data,
            bus.reg_write_en_2, bus.reg_write_dest_2, bus.reg_write_data_2,
            mem[bus.reg_read_addr_2]);
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: default-config file (bypass on), a bypass-off copy and a narrow
// 16x8 variant, all sharing one clock and reset.
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
    regfile_multiport_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    regfile_multiport_if #(.DATA_W(16), .ADDR_W(3)) if_c ();

    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .INIT_MODE(1), .BYPASS(1), .ZERO_REG(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .INIT_MODE(1), .BYPASS(0), .ZERO_REG(1))
        dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    regfile_multiport #(.DATA_W(16), .ADDR_W(3), .INIT_MODE(0), .BYPASS(1), .ZERO_REG(0))
        dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.reg_write_en = 0; if_a.reg_write_dest = '0; if_a.reg_write_data = '0;
        if_a.reg_write_en_2 = 0; if_a.reg_write_dest_2 = '0; if_a.reg_write_data_2 = '0;
        if_a.reg_read_addr_1 = '0; if_a.reg_read_addr_2 = '0;
        if_b.reg_write_en = 0; if_b.reg_write_dest = '0; if_b.reg_write_data = '0;
        if_b.reg_write_en_2 = 0; if_b.reg_write_dest_2 = '0; if_b.reg_write_data_2 = '0;
        if_b.reg_read_addr_1 = '0; if_b.reg_read_addr_2 = '0;
        if_c.reg_write_en = 0; if_c.reg_write_dest = '0; if_c.reg_write_data = '0;
        if_c.reg_write_en_2 = 0; if_c.reg_write_dest_2 = '0; if_c.reg_write_data_2 = '0;
        if_c.reg_read_addr_1 = '0; if_c.reg_read_addr_2 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        check("reset_ready_a", 32'(if_a.ready), 32'h0);
        check("reset_read_a", if_a.reg_read_data_1, 32'h0);
        reset = 1'b0;

        // Init sweep; an external write and a bypass candidate are presented on edge 3.
        for (int i = 1; i <= 32; i++) begin
            if (i == 3) begin
                if_a.reg_write_en = 1; if_a.reg_write_dest = 5'd5; if_a.reg_write_data = 32'hDEADBEEF;
                if_a.reg_read_addr_1 = 5'd5;
                #1;
                check("init_read_zero", if_a.reg_read_data_1, 32'h0);
            end
            tick();
            if_a.reg_write_en = 0;
            if (i == 31) check("ready_edge31", 32'(if_a.ready), 32'h0);
            if (i == 32) check("ready_edge32", 32'(if_a.ready), 32'h1);
            if (i == 7)  check("ready_c_edge7", 32'(if_c.ready), 32'h0);
            if (i == 8)  check("ready_c_edge8", 32'(if_c.ready), 32'h1);
        end

        if_a.reg_read_addr_1 = 5'd7; if_a.reg_read_addr_2 = 5'd31;
        #1;
        check("sweep_r7", if_a.reg_read_data_1, 32'h00000007);
        check("sweep_r31", if_a.reg_read_data_2, 32'h0000001F);
        if_a.reg_read_addr_1 = 5'd0; if_a.reg_read_addr_2 = 5'd5;
        #1;
        check("sweep_r0", if_a.reg_read_data_1, 32'h0);
        check("init_write_ignored", if_a.reg_read_data_2, 32'h00000005);

        // Dual write collision on reg 9: port B wins, including on the bypass path.
        if_a.reg_write_en = 1; if_a.reg_write_dest = 5'd9; if_a.reg_write_data = 32'h11111111;
        if_a.reg_write_en_2 = 1; if_a.reg_write_dest_2 = 5'd9; if_a.reg_write_data_2 = 32'h22222222;
        if_a.reg_read_addr_1 = 5'd9;
        if_b.reg_write_en = 1; if_b.reg_write_dest = 5'd9; if_b.reg_write_data = 32'h11111111;
        if_b.reg_write_en_2 = 1; if_b.reg_write_dest_2 = 5'd9; if_b.reg_write_data_2 = 32'h22222222;
        if_b.reg_read_addr_1 = 5'd9;
        #1;
        check("collide_bypass_a", if_a.reg_read_data_1, 32'h22222222);
        check("collide_nobypass_b", if_b.reg_read_data_1, 32'h00000009);
        tick();
        idle_all();
        if_a.reg_read_addr_1 = 5'd9; if_b.reg_read_addr_1 = 5'd9;
        #1;
        check("collide_a_r9", if_a.reg_read_data_1, 32'h22222222);
        check("collide_b_r9", if_b.reg_read_data_1, 32'h22222222);

        // Same collision to reg 0 is discarded.
        if_a.reg_write_en = 1; if_a.reg_write_dest = 5'd0; if_a.reg_write_data = 32'h11111111;
        if_a.reg_write_en_2 = 1; if_a.reg_write_dest_2 = 5'd0; if_a.reg_write_data_2 = 32'h22222222;
        if_a.reg_read_addr_1 = 5'd0;
        #1;
        check("zero_bypass", if_a.reg_read_data_1, 32'h0);
        tick();
        idle_all();
        #1;
        check("zero_after", if_a.reg_read_data_1, 32'h0);

        // Bypass on reg 12 versus stored-only read.
        if_a.reg_write_en = 1; if_a.reg_write_dest = 5'd12; if_a.reg_write_data = 32'hCAFEF00D;
        if_a.reg_read_addr_1 = 5'd12;
        if_b.reg_write_en = 1; if_b.reg_write_dest = 5'd12; if_b.reg_write_data = 32'hCAFEF00D;
        if_b.reg_read_addr_1 = 5'd12;
        #1;
        check("bypass_a_same", if_a.reg_read_data_1, 32'hCAFEF00D);
        check("bypass_b_same", if_b.reg_read_data_1, 32'h0000000C);
        tick();
        idle_all();
        if_a.reg_read_addr_2 = 5'd12; if_b.reg_read_addr_1 = 5'd12;
        #1;
        check("bypass_a_next", if_a.reg_read_data_2, 32'hCAFEF00D);
        check("bypass_b_next", if_b.reg_read_data_1, 32'hCAFEF00D);

        // Narrow variant: zero sweep, reg 0 is ordinary.
        for (int k = 0; k < 8; k++) begin
            if_c.reg_read_addr_1 = 3'(k);
            #1;
            check($sformatf("c_zero_r%0d", k), 32'(if_c.reg_read_data_1), 32'h0);
        end
        if_c.reg_write_en = 1; if_c.reg_write_dest = 3'd0; if_c.reg_write_data = 16'hBEEF;
        tick();
        idle_all();
        if_c.reg_read_addr_2 = 3'd0;
        #1;
        check("c_r0_write", 32'(if_c.reg_read_data_2), 32'h0000BEEF);

        // Reset after a write, then again mid-sweep.
        if_a.reg_write_en = 1; if_a.reg_write_dest = 5'd3; if_a.reg_write_data = 32'h0000ABCD;
        tick();
        idle_all();
        if_a.reg_read_addr_1 = 5'd3;
        #1;
        check("run_r3_write", if_a.reg_read_data_1, 32'h0000ABCD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_ready_low", 32'(if_a.ready), 32'h0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("sweep1_ready_e%0d", i), 32'(if_a.ready), 32'h0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_ready_low", 32'(if_a.ready), 32'h0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i < 32) check($sformatf("sweep2_ready_e%0d", i), 32'(if_a.ready), 32'h0);
            else        check("sweep2_ready_e32", 32'(if_a.ready), 32'h1);
        end
        #1;
        check("rst_r3_restored", if_a.reg_read_data_1, 32'h00000003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
